// File: rtl/add_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_accum_pkg
//  Brief    : Shared types and constants for the add_accum_seq accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
package add_accum_pkg;

    // Default operand/accumulator width and burst-length field width.
    localparam int c_default_n     = 4;
    localparam int c_default_len_w = 8;

    // Saturation value at the default width. Wider instances replicate bit 0.
    localparam logic [c_default_n-1:0] c_sat_ones = '1;

    // Accumulator control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : add_accum_pkg
`default_nettype wire

// File: rtl/add_accum_adder.sv
`default_nettype none
// ============================================================================
//  Module   : add_accum_adder
//  Brief    : Combinational N-bit ripple-carry adder built from 1-bit
//             full-adder cells chained through a carry vector.
//  Revision : 1.0 - initial release
// ============================================================================
module add_accum_adder
    import add_accum_pkg::*;
#(
    parameter int N = c_default_n
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Carry chain: w_carry[i] is the carry into bit i.
    logic [N:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < N; i++) begin : g_fa
            // Propagate term shared by the sum and carry equations.
            logic w_prop;
            assign w_prop       = a[i] ^ b[i];
            assign sum[i]       = w_prop ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & b[i]) | (w_prop & w_carry[i]);
        end
    endgenerate

    assign cout = w_carry[N];

endmodule : add_accum_adder
`default_nettype wire

// File: rtl/add_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module   : add_accum_seq
//  Brief    : Sequential multi-operand accumulator. Takes a burst of len_in
//             operands over valid/ready, sums them through a ripple-carry
//             stage and holds the result (plus a sticky carry) until ack_in.
//  Options  : ADD_ACCUM_SATURATE_EN - clamp the accumulator to all ones on
//             any carry out instead of wrapping modulo 2^N.
//  Revision : 1.0 - initial release
// ============================================================================
module add_accum_seq
    import add_accum_pkg::*;
#(
    parameter int N     = c_default_n,
    parameter int LEN_W = c_default_len_w
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [N-1:0]     num_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [N-1:0]     sum_out,
    output logic             carry_out,
    output logic             done_out,
    input  logic             ack_in
);

`ifdef ADD_ACCUM_SATURATE_EN
    // Saturation value at this instance's width.
    localparam logic [N-1:0] c_sat = {N{c_sat_ones[0]}};
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;

    logic [N-1:0]     r_acc;
    logic [N-1:0]     w_acc_next;
    logic             r_carry;
    logic             w_carry_next;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_next;

    // Result registers: only updated on entry to DONE or cleared on start,
    // so they stay stable through DONE and after the acknowledge.
    logic [N-1:0]     r_sum;
    logic [N-1:0]     w_sum_next;
    logic             r_sum_carry;
    logic             w_sum_carry_next;

    // ------------------------------------------------------------------
    // Adder stage and handshake decode
    // ------------------------------------------------------------------
    logic [N-1:0]     w_add_sum;
    logic             w_add_cout;
    logic             w_xfer;
    logic             w_start;
    logic             w_last_beat;

    add_accum_adder #(
        .N (N)
    ) u_adder (
        .a    (r_acc),
        .b    (num_in),
        .cin  (1'b0),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    // ready is decoded from state, so a beat transfers whenever we are in
    // ACCUM and the producer presents valid data.
    assign w_xfer      = (r_state == ACCUM) && valid_in;
    assign w_start     = (r_state == IDLE) && start_in;
    assign w_last_beat = w_xfer && (r_cnt == LEN_W'(1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a zero-length burst skips ACCUM entirely, and ack
    // takes priority over a simultaneous start while in DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    if (len_in != '0) begin
                        w_state_next = ACCUM;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            ACCUM: begin
                if (w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (ack_in) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded purely from state.
    always_comb begin
        ready_out = 1'b0;
        done_out  = 1'b0;
        case (r_state)
            ACCUM:   ready_out = 1'b1;
            DONE:    done_out  = 1'b1;
            default: begin
                ready_out = 1'b0;
                done_out  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Next values for accumulator, sticky carry, beat counter and result.
    always_comb begin
        w_acc_next       = r_acc;
        w_carry_next     = r_carry;
        w_cnt_next       = r_cnt;
        w_sum_next       = r_sum;
        w_sum_carry_next = r_sum_carry;

        if (w_start) begin
            // A new burst clears everything, including the held result.
            w_acc_next       = '0;
            w_carry_next     = 1'b0;
            w_cnt_next       = len_in;
            w_sum_next       = '0;
            w_sum_carry_next = 1'b0;
        end else if (w_xfer) begin
`ifdef ADD_ACCUM_SATURATE_EN
            if (w_add_cout) begin
                w_acc_next = c_sat;
            end else begin
                w_acc_next = w_add_sum;
            end
`else
            w_acc_next = w_add_sum;
`endif
            w_carry_next = r_carry | w_add_cout;
            w_cnt_next   = r_cnt - LEN_W'(1);
        end

        // Capture the final value on the edge that enters DONE so the
        // result is already valid in the first DONE cycle.
        if ((r_state != DONE) && (w_state_next == DONE)) begin
            w_sum_next       = w_acc_next;
            w_sum_carry_next = w_carry_next;
        end
    end

    // Datapath registers; reset abandons any burst and zeroes the result.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_sum_carry <= 1'b0;
        end else begin
            r_acc       <= w_acc_next;
            r_carry     <= w_carry_next;
            r_cnt       <= w_cnt_next;
            r_sum       <= w_sum_next;
            r_sum_carry <= w_sum_carry_next;
        end
    end

    assign sum_out   = r_sum;
    assign carry_out = r_sum_carry;

endmodule : add_accum_seq
`default_nettype wire

// File: doc/add_accum_seq.md
Name: add_accum_seq

Overview:
- Sequential multi-operand accumulator that sits directly upstream of the bit-level adder datapath.
- Accepts a burst of len_in operands over a valid/ready handshake.
- Feeds each beat plus the running sum through an n-bit ripple-carry stage.
- Presents the final sum and a sticky carry flag, held until the consumer acknowledges.

Parameters:
- N, 4, operand/accumulator width in bits.
- LEN_W, 8, width of the burst-length field and the beat counter.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- start_in  input  1  begin a new burst; sampled only in IDLE.
- len_in  input  LEN_W  number of operands in the burst; sampled with start_in.
- num_in  input  N  operand for the current beat.
- valid_in  input  1  num_in is valid.
- ready_out  output  1  block accepts num_in this cycle.
- sum_out  output  N  accumulated sum; stable while done_out=1.
- carry_out  output  1  sticky: any beat produced a carry out of bit N-1.
- done_out  output  1  result available.
- ack_in  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is asynchronous and active-high. On reset, state=IDLE and the accumulator, counter, sum_out, carry_out, ready_out and done_out are all 0.
- FSM has three states: IDLE, ACCUM, DONE. Outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- IDLE:
  - ready_out=0, done_out=0.
  - start_in=1 with len_in!=0: acc<=0, carry<=0, cnt<=len_in, go to ACCUM.
  - start_in=1 with len_in==0: acc<=0, carry<=0, go directly to DONE (empty burst yields sum 0, carry 0).
- ACCUM:
  - ready_out=1.
  - A beat transfers when valid_in&ready_out. On a transfer: acc<=acc+num_in through the N-bit adder, with carry-in 0. The sum wraps modulo 2^N. carry|=adder carry-out; cnt<=cnt-1.
  - A transfer with cnt==1 moves to DONE on the next edge.
  - valid_in=0 holds all state; there is no timeout.
- DONE:
  - done_out=1, ready_out=0, sum_out=acc, carry_out=carry.
  - ack_in=1 returns to IDLE next cycle. sum_out and carry_out keep their values until the next burst's start clears them.
- Latency: done_out rises exactly one cycle after the last beat's transfer edge.
- Throughput: one beat per cycle while valid_in is held high.
- start_in outside IDLE is ignored. ack_in outside DONE is ignored.
- start_in and ack_in asserted together in DONE: ack_in wins. Return to IDLE; start_in must be re-presented in IDLE.
- Reset mid-burst: the burst is abandoned immediately and all outputs are 0. No partial result is reported.
- cnt is LEN_W wide; the maximum burst is 2^LEN_W-1 beats.

Optional Feature:
- Macro: ADD_ACCUM_SATURATE_EN.
- Defined: when a beat's adder carry-out is 1, acc<=all ones (2^N-1) and carry<=1. Further beats leave acc at all ones.
- Not defined: wrap-around behaviour as above, with carry_out as a sticky flag only.

Decomposition:
- Shared package add_accum_pkg holds:
  - the state enum typedef {IDLE, ACCUM, DONE};
  - localparam defaults for N and LEN_W;
  - the saturation constant (all ones of width N).
- One natural sub-module, add_accum_adder: a combinational N-bit ripple-carry adder (a, b, cin → sum, cout) built with a generate loop of 1-bit full-adder cells.
- The FSM, counter and registers stay in the top module.

Test Plan (N=4, LEN_W=8):
- Reset then idle: rst_in pulse, no start → ready_out=0, done_out=0, sum_out=0, carry_out=0.
- Basic burst: start, len=3, beats 2,3,4 back-to-back → done_out one cycle after beat 3, sum_out=9, carry_out=0; ack_in → IDLE.
- Wrap with stalls: len=2, beats 12 then 7, valid_in low 2 cycles between beats → sum_out=3, carry_out=1. With ADD_ACCUM_SATURATE_EN: sum_out=15, carry_out=1.
- Empty burst: start, len=0 → DONE next cycle, sum_out=0, carry_out=0, no beats accepted.
- Reset mid-burst: len=4, two beats accepted, assert rst_in asynchronously → all outputs 0 immediately. A new burst len=1, beat 5 → sum_out=5.
- Protocol corners: start_in during ACCUM is ignored (count unaffected). In DONE, hold ack_in low 5 cycles → sum_out stable. start_in and ack_in together → IDLE, no new burst.
